uc_hazard_hold: RTL and testbench

- Hazard/hold generator directly upstream of the decode-side control stage.
- Owns the single-entry EX-stage tracking register (dest SelC, MR, MW).
- Detects load-use hazards and outstanding memory accesses, and drives HOLD so the downstream stage forces a NOP (SelC=35, Type=0).
- Also registers MR/MW toward memory.

---
 rtl/uc_hazard_hold_pkg.sv | 13 +
 rtl/uc_hazard_cmp.sv | 14 +
 rtl/uc_hazard_hold.sv | 145 ++++++++++++++
 tb/tb_uc_hazard_hold.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/uc_hazard_hold_pkg.sv
// Shared encodings for the hazard/hold generator: NOP codes, field widths, FSM states.
package uc_hazard_hold_pkg;
    localparam int SELC_W = 6;
    localparam int TYPE_W = 7;
    localparam logic [SELC_W-1:0] NOP_SELC = 6'd35;
    localparam logic [TYPE_W-1:0] TYPE_NOP = 7'b0;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        MEM_WAIT  = 2'd2
    } state_t;
endpackage

// File: rtl/uc_hazard_cmp.sv
// Load-use hazard comparator: EX destination against both decode sources, NOP destination masked.
module uc_hazard_cmp
    import uc_hazard_hold_pkg::*;
(
    input  logic              valid,
    input  logic              ex_mr,
    input  logic [SELC_W-1:0] ex_selc,
    input  logic [SELC_W-1:0] sel_a,
    input  logic [SELC_W-1:0] sel_b,
    output logic              hz
);
    assign hz = valid & ex_mr & (ex_selc != NOP_SELC) &
                ((ex_selc == sel_a) | (ex_selc == sel_b));
endmodule

// File: rtl/uc_hazard_hold.sv
// Hazard/hold generator with EX tracking register and memory strobes.
// Optional memory timeout error enabled by defining UC_HOLD_TIMEOUT_EN.
//
// state     | meaning
// RUN       | normal issue; HOLD only on a fresh hazard or busy memory
// LOAD_WAIT | bubble in EX, counting down the remaining load latency
// MEM_WAIT  | EX access outstanding, EX frozen until MEM_READY
module uc_hazard_hold
    import uc_hazard_hold_pkg::*;
#(
    parameter int LOAD_LAT = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              VALID_IN,
    input  logic [SELC_W-1:0] SelA_in,
    input  logic [SELC_W-1:0] SelB_in,
    input  logic [SELC_W-1:0] SelC_in,
    input  logic              MR_IN,
    input  logic              MW_IN,
    input  logic              MEM_READY,
    output logic              HOLD,
    output logic [SELC_W-1:0] EX_SelC,
    output logic              MR_OUT,
    output logic              MW_OUT,
    output logic              MEM_ERR
);
    localparam logic [7:0] LAT_M1 = 8'(LOAD_LAT - 1);

    if (LOAD_LAT < 1 || LOAD_LAT > 7 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("uc_hazard_hold: LOAD_LAT must be 1..7 and TIMEOUT 1..255");
    end

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic       hz, busy, tmo;
    logic       ex_ld, ex_bub, err_set;

    uc_hazard_cmp u_cmp (
        .valid   (VALID_IN),
        .ex_mr   (MR_OUT),
        .ex_selc (EX_SelC),
        .sel_a   (SelA_in),
        .sel_b   (SelB_in),
        .hz      (hz)
    );

    assign busy = (MR_OUT | MW_OUT) & ~MEM_READY;

`ifdef UC_HOLD_TIMEOUT_EN
    localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);
    assign tmo = (state == MEM_WAIT) & ~MEM_READY & (cnt >= TMO_CNT);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        HOLD    = 1'b0;
        ex_ld   = 1'b0;
        ex_bub  = 1'b0;
        err_set = 1'b0;
        case (state)
            RUN: begin
                if (busy) begin
                    HOLD    = 1'b1;
                    state_d = MEM_WAIT;
                    cnt_d   = 8'd0;
                end else if (hz) begin
                    HOLD   = 1'b1;
                    ex_bub = 1'b1;
                    cnt_d  = LAT_M1;
                    if (LOAD_LAT > 1) state_d = LOAD_WAIT;
                end else begin
                    ex_ld = 1'b1;
                end
            end
            LOAD_WAIT: begin
                // the hazard-detect cycle already counted as the first HOLD cycle
                HOLD = 1'b1;
                if (cnt != 8'd0) cnt_d = cnt - 8'd1;
                if (cnt <= 8'd1) state_d = RUN;
            end
            MEM_WAIT: begin
                if (tmo) begin
                    ex_bub  = 1'b1;
                    err_set = 1'b1;
                    state_d = RUN;
                    cnt_d   = 8'd0;
                end else if (busy) begin
                    HOLD = 1'b1;
                    if (cnt != 8'hFF) cnt_d = cnt + 8'd1;
                end else if (hz) begin
                    HOLD   = 1'b1;
                    ex_bub = 1'b1;
                    cnt_d  = LAT_M1;
                    state_d = (LOAD_LAT > 1) ? LOAD_WAIT : RUN;
                end else begin
                    ex_ld   = 1'b1;
                    state_d = RUN;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= RUN;
            cnt     <= 8'd0;
            EX_SelC <= NOP_SELC;
            MR_OUT  <= 1'b0;
            MW_OUT  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (ex_ld) begin
                EX_SelC <= VALID_IN ? SelC_in : NOP_SELC;
                MR_OUT  <= VALID_IN & MR_IN;
                MW_OUT  <= VALID_IN & MW_IN;
            end else if (ex_bub) begin
                EX_SelC <= NOP_SELC;
                MR_OUT  <= 1'b0;
                MW_OUT  <= 1'b0;
            end
        end
    end

`ifdef UC_HOLD_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) MEM_ERR <= 1'b0;
        else if (err_set) MEM_ERR <= 1'b1;
    end
`else
    assign MEM_ERR = 1'b0;
    logic unused_err;
    assign unused_err = err_set;
`endif
endmodule

// File: tb/tb_uc_hazard_hold.sv
// Directed bench for uc_hazard_hold with the default LOAD_LAT=2.
module tb_uc_hazard_hold;
    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       VALID_IN;
    logic [5:0] SelA_in, SelB_in, SelC_in;
    logic       MR_IN, MW_IN, MEM_READY;
    logic       HOLD;
    logic [5:0] EX_SelC;
    logic       MR_OUT, MW_OUT, MEM_ERR;

    int n_cmp = 0;
    int n_bad = 0;
    int hc;

    uc_hazard_hold dut (
        .CLK(CLK), .RESET_N(RESET_N), .VALID_IN(VALID_IN),
        .SelA_in(SelA_in), .SelB_in(SelB_in), .SelC_in(SelC_in),
        .MR_IN(MR_IN), .MW_IN(MW_IN), .MEM_READY(MEM_READY),
        .HOLD(HOLD), .EX_SelC(EX_SelC), .MR_OUT(MR_OUT), .MW_OUT(MW_OUT),
        .MEM_ERR(MEM_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // apply decode inputs, then wait to mid-cycle for sampling
    task automatic drv(input logic v, input logic [5:0] a, input logic [5:0] b,
                       input logic [5:0] c, input logic mr, input logic mw, input logic rdy);
        VALID_IN = v; SelA_in = a; SelB_in = b; SelC_in = c;
        MR_IN = mr; MW_IN = mw; MEM_READY = rdy;
        @(negedge CLK);
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET_N = 1'b0;
        VALID_IN = 0; SelA_in = 0; SelB_in = 0; SelC_in = 0;
        MR_IN = 0; MW_IN = 0; MEM_READY = 1;
        #12;
        chk("rst_hold", HOLD, 0);
        chk("rst_ex", EX_SelC, 35);
        chk("rst_mr", MR_OUT, 0);
        chk("rst_mw", MW_OUT, 0);
        chk("rst_err", MEM_ERR, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        adv();

        // load-use on SelA: two HOLD cycles, bubble, then the instruction enters EX
        drv(1, 6'd1, 6'd2, 6'd5, 1, 0, 1);
        chk("lu_issue_hold", HOLD, 0);
        adv();
        chk("lu_ex_load", EX_SelC, 5);
        chk("lu_mr_load", MR_OUT, 1);
        drv(1, 6'd5, 6'd9, 6'd10, 0, 0, 1);
        chk("lu_hold1", HOLD, 1);
        adv();
        drv(1, 6'd5, 6'd9, 6'd10, 0, 0, 1);
        chk("lu_hold2", HOLD, 1);
        chk("lu_bubble", EX_SelC, 35);
        chk("lu_bubble_mr", MR_OUT, 0);
        adv();
        drv(1, 6'd5, 6'd9, 6'd10, 0, 0, 1);
        chk("lu_release", HOLD, 0);
        adv();
        drv(0, 6'd0, 6'd0, 6'd0, 0, 0, 1);
        chk("lu_enter_ex", EX_SelC, 10);
        chk("lu_idle_hold", HOLD, 0);
        adv();
        chk("novalid_nop", EX_SelC, 35);

        // load to NOP_SELC never hazards
        drv(1, 6'd0, 6'd0, 6'd35, 1, 0, 1);
        adv();
        drv(1, 6'd35, 6'd3, 6'd12, 0, 0, 1);
        chk("nop_dest_mr", MR_OUT, 1);
        chk("nop_dest_hold", HOLD, 0);
        adv();
        chk("nop_dest_next", EX_SelC, 12);

        // store in EX never hazards
        drv(1, 6'd0, 6'd0, 6'd5, 0, 1, 1);
        adv();
        drv(1, 6'd4, 6'd5, 6'd13, 0, 0, 1);
        chk("st_mw", MW_OUT, 1);
        chk("st_hold", HOLD, 0);
        adv();
        chk("st_next", EX_SelC, 13);
        drv(0, 6'd0, 6'd0, 6'd0, 0, 0, 0);
        chk("idle_rdy_ignored", HOLD, 0);
        adv();

        // memory wait: 4 cycles not ready, EX frozen, HOLD drops when ready rises
        drv(1, 6'd0, 6'd0, 6'd20, 1, 0, 1);
        adv();
        for (int i = 0; i < 4; i++) begin
            drv(1, 6'd1, 6'd2, 6'd21, 0, 0, 0);
            chk($sformatf("mw_hold%0d", i), HOLD, 1);
            chk($sformatf("mw_frozen%0d", i), EX_SelC, 20);
            adv();
        end
        drv(1, 6'd1, 6'd2, 6'd21, 0, 0, 1);
        chk("mw_ready_hold", HOLD, 0);
        adv();
        chk("mw_next", EX_SelC, 21);
        chk("mw_next_mr", MR_OUT, 0);

        // load stalled by memory, then load-use on SelB: 3 + 2 HOLD cycles
        drv(1, 6'd0, 6'd0, 6'd7, 1, 0, 1);
        adv();
        hc = 0;
        for (int i = 0; i < 8; i++) begin
            drv(1, 6'd3, 6'd7, 6'd22, 0, 0, (i >= 3) ? 1'b1 : 1'b0);
            if (HOLD) hc++;
            adv();
        end
        chk("comb_hold_total", hc, 5);
        chk("comb_next", EX_SelC, 22);

        // async reset in the middle of MEM_WAIT
        drv(1, 6'd0, 6'd0, 6'd30, 1, 0, 1);
        adv();
        drv(1, 6'd1, 6'd2, 6'd31, 0, 0, 0);
        adv();
        drv(1, 6'd1, 6'd2, 6'd31, 0, 0, 0);
        chk("pre_rst_hold", HOLD, 1);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("midrst_hold", HOLD, 0);
        chk("midrst_ex", EX_SelC, 35);
        chk("midrst_mr", MR_OUT, 0);
        chk("midrst_mw", MW_OUT, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        adv();
        drv(1, 6'd0, 6'd0, 6'd40, 0, 0, 1);
        chk("post_rst_hold", HOLD, 0);
        adv();
        chk("post_rst_ex", EX_SelC, 40);
        chk("err_stays0", MEM_ERR, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
